lamp_input_conditioner: RTL and testbench

LAMP_INPUT_CONDITIONER -- requirements
Module: lamp_input_conditioner

---
 rtl/lamp_cond_pkg.sv | 14 +
 rtl/lamp_input_conditioner_if.sv | 13 +
 rtl/lamp_debounce.sv | 113 +++++++++++
 rtl/lamp_input_conditioner.sv | 64 ++++++
 tb/tb_lamp_input_conditioner.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lamp_cond_pkg.sv
// Shared types for the lamp input conditioner: debounce state encoding and default filter depth.
// Optional LAMP_INPUT_SYNC_EN adds a 2-flop synchroniser per channel (see lamp_debounce).
package lamp_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_LOW_CHK  = 2'd1,
        ST_HIGH     = 2'd2,
        ST_HIGH_CHK = 2'd3
    } deb_state_e;

endpackage

// File: rtl/lamp_input_conditioner_if.sv
// Lamp channel bundle: raw level in, debounced level and pre-edge rise flag out.
// W=1 per debounce channel; wider instances carry the whole lamp bus.
interface lamp_input_conditioner_if #(
    parameter int W = 1
);
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] rise;

    // master: the debouncer producing level/rise; slave: the consumer feeding raw
    modport master (input raw, output level, output rise);
    modport slave  (output raw, input level, input rise);
endinterface

// File: rtl/lamp_debounce.sv
// One lamp channel: optional sync (LAMP_INPUT_SYNC_EN), 4-state debounce FSM, registered level.
// Level changes DEBOUNCE_CYCLES edges after a held change (+2 with sync); no backpressure.
module lamp_debounce
    import lamp_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    lamp_input_conditioner_if.master ch
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sample;

`ifdef LAMP_INPUT_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], ch.raw[0]};

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign sample = sync_q[1];
`else
    assign sample = ch.raw[0];
`endif

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise;

    // cnt_q holds samples already accepted; the final matching sample switches state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sample) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                        rise    = 1'b1;
                    end else begin
                        state_d = ST_LOW_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_LOW_CHK: begin
                if (!sample) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sample) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_HIGH_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_HIGH_CHK: begin
                if (sample) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_HIGH) || (state_d == ST_HIGH_CHK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign ch.level = level_q;
    // rise marks the coming edge on which HIGH is entered; the top registers it
    assign ch.rise  = rise;

endmodule

// File: rtl/lamp_input_conditioner.sv
// Three debounced lamp inputs with registered one-hot press pulses and a conflict pulse.
// Pulses land on the same edge the level goes high; no backpressure.
module lamp_input_conditioner
    import lamp_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] raw_lamp,
    output logic       lamp1,
    output logic       lamp2,
    output logic       lamp3,
    output logic [2:0] lamp_level,
    output logic       conflict
);

    logic [2:0] rise;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        lamp_input_conditioner_if #(.W(1)) ch_if ();

        assign ch_if.raw      = raw_lamp[gi];
        assign rise[gi]       = ch_if.rise[0];
        assign lamp_level[gi] = ch_if.level[0];

        lamp_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .ch    (ch_if)
        );
    end

    logic [2:0] lamp_q, lamp_d;
    logic       conflict_q, conflict_d;

    // Simultaneous accepts are ambiguous to the sequence detector, so none is forwarded
    always_comb begin
        lamp_d     = '0;
        conflict_d = 1'b0;
        if (rise != 3'd0) begin
            if ((rise & (rise - 3'd1)) == 3'd0) lamp_d     = rise;
            else                                 conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lamp_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            lamp_q     <= lamp_d;
            conflict_q <= conflict_d;
        end
    end

    assign lamp1    = lamp_q[0];
    assign lamp2    = lamp_q[1];
    assign lamp3    = lamp_q[2];
    assign conflict = conflict_q;

endmodule

// File: tb/tb_lamp_input_conditioner.sv
// Bench for lamp_input_conditioner: per-cycle scoreboard from a run-length model plus directed scenarios.
module tb_lamp_input_conditioner;

    localparam int D = 4;
`ifdef LAMP_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = D + SYNC;

    logic clk = 1'b0;
    logic reset;
    logic conflict_w;

    always #5 clk = ~clk;

    lamp_input_conditioner_if #(.W(3)) bus ();

    lamp_input_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_lamp   (bus.raw),
        .lamp1      (bus.rise[0]),
        .lamp2      (bus.rise[1]),
        .lamp3      (bus.rise[2]),
        .lamp_level (bus.level),
        .conflict   (conflict_w)
    );

    typedef struct packed {
        logic       conflict;
        logic [2:0] lamps;
        logic [2:0] level;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model: level flips after D consecutive samples that differ from it
    logic [2:0] m_lvl = '0;
    int         m_run [3] = '{0, 0, 0};
    logic [2:0] m_s0 = '0;
    logic [2:0] m_s1 = '0;

    int         edge_idx;
    int         pulse_cnt [3];
    int         first_pulse [3];
    int         conflict_cnt;
    int         first_conflict;
    logic [2:0] level_or;
    obs_t       last_obs;
    int         order_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_stats();
        edge_idx       = 0;
        conflict_cnt   = 0;
        first_conflict = -1;
        level_or       = '0;
        order_q.delete();
        for (int i = 0; i < 3; i++) begin
            pulse_cnt[i]   = 0;
            first_pulse[i] = -1;
        end
    endtask

    task automatic step(input logic [2:0] raw, input logic rst);
        obs_t       e;
        obs_t       got;
        logic [2:0] s;
        logic [2:0] rose;
        @(negedge clk);
        bus.raw = raw;
        reset   = rst;
        s    = (SYNC != 0) ? m_s1 : raw;
        rose = '0;
        if (rst) begin
            m_lvl = '0;
            m_s0  = '0;
            m_s1  = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            m_s1 = m_s0;
            m_s0 = raw;
            for (int i = 0; i < 3; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = s[i];
                        m_run[i] = 0;
                        rose[i]  = s[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        e.level    = m_lvl;
        e.lamps    = ($countones(rose) == 1) ? rose : 3'b000;
        e.conflict = ($countones(rose) > 1);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = {conflict_w, bus.rise, bus.level};
        e   = exp_q.pop_front();
        check("cycle", 32'(got), 32'(e));

        edge_idx++;
        last_obs = got;
        level_or = level_or | got.level;
        for (int i = 0; i < 3; i++) begin
            if (got.lamps[i]) begin
                pulse_cnt[i]++;
                order_q.push_back(i + 1);
                if (first_pulse[i] < 0) first_pulse[i] = edge_idx;
            end
        end
        if (got.conflict) begin
            conflict_cnt++;
            if (first_conflict < 0) first_conflict = edge_idx;
        end
    endtask

    task automatic hold(input logic [2:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    initial begin
        int   seq_code;
        logic [2:0] rv;
        reset   = 1'b1;
        bus.raw = '0;

        // reset state
        clear_stats();
        step(3'b000, 1'b1);
        step(3'b111, 1'b1);
        check("reset_state", 32'(last_obs), 32'd0);

        // single press held from before edge 1
        clear_stats();
        hold(3'b001, 10);
        check("p1_first_edge", first_pulse[0], LAT);
        check("p1_pulse_count", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 1);
        check("p1_level", 32'(last_obs.level), 32'h1);
        clear_stats();
        hold(3'b000, 10);
        check("release_no_pulse", pulse_cnt[0] + conflict_cnt, 0);
        check("release_level", 32'(last_obs.level), 32'h0);

        // glitch shorter than the filter
        clear_stats();
        hold(3'b001, D - 1);
        hold(3'b000, 8);
        check("glitch_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
        check("glitch_level", 32'(level_or), 32'h0);

        // two channels at once
        clear_stats();
        hold(3'b011, 10);
        check("conf_edge", first_conflict, LAT);
        check("conf_count", conflict_cnt, 1);
        check("conf_no_lamp", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);
        check("conf_level", 32'(last_obs.level), 32'h3);
        hold(3'b000, 10);

        // ordered presses
        clear_stats();
        hold(3'b001, 6);
        hold(3'b000, 8);
        hold(3'b010, 6);
        hold(3'b000, 8);
        hold(3'b100, 6);
        hold(3'b000, 8);
        seq_code = (order_q.size() == 3) ? order_q[0] * 100 + order_q[1] * 10 + order_q[2]
                                         : order_q.size();
        check("seq_order", seq_code, 123);

        // reset mid-check discards the partial count
        clear_stats();
        step(3'b100, 1'b0);
        step(3'b100, 1'b1);
        clear_stats();
        hold(3'b100, 10);
        check("rst_mid_edge", first_pulse[2], LAT);
        check("rst_mid_count", pulse_cnt[2], 1);
        hold(3'b000, 10);

        // random segments with occasional reset
        for (int seg = 0; seg < 60; seg++) begin
            rv = 3'($urandom_range(0, 7));
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                step(rv, ($urandom_range(0, 39) == 0));
            end
        end

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
